// File: rtl/conv_sched_pkg.sv
// Shared definitions for the convolution job scheduler: state encoding and
// default sizing constants used by conv_sched and its watchdog.
package conv_sched_pkg;

    localparam int NUM_FILTERS_DEF = 8;
    localparam int DATA_WIDTH_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_FINISH = 3'd4
    } sched_state_e;

endpackage

// File: rtl/conv_watchdog.sv
// Per-pass watchdog: counts consecutive RUN cycles and flags expiry on the
// LIMIT-th cycle without a core completion.
module conv_watchdog #(
    parameter int LIMIT = 65535,
    localparam int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Holding at zero outside RUN makes every entry to RUN start from a clean count.
    always_comb begin
        cnt_d = '0;
        if (run_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/conv_sched.sv
// Convolution job scheduler: sequences weight loads and conv_core passes per filter.
// Optional watchdog on each core pass is enabled by defining CONV_SCHED_TIMEOUT_EN.
import conv_sched_pkg::*;

module conv_sched #(
    parameter int NUM_FILTERS    = NUM_FILTERS_DEF,
    parameter int FILT_W         = $clog2(NUM_FILTERS) + 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [FILT_W-1:0] num_filt,
    input  logic              abort,
    output logic              wload_req,
    output logic [FILT_W-1:0] wload_idx,
    input  logic              wload_ack,
    output logic              core_start,
    input  logic              core_done,
    output logic [FILT_W-1:0] filt_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    sched_state_e      state_q, state_d;
    logic [FILT_W-1:0] count_q, count_d;
    logic [FILT_W-1:0] filt_idx_q, filt_idx_d;
    logic              err_q, err_d;
    logic [FILT_W-1:0] clamped_cnt;
    logic              timeout;

    logic              busy_q, wload_req_q, core_start_q, done_q;
    logic [FILT_W-1:0] wload_idx_q;

`ifdef CONV_SCHED_TIMEOUT_EN
    conv_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .run_i     (state_q == ST_RUN),
        .expired_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    assign clamped_cnt = (num_filt > FILT_W'(NUM_FILTERS)) ? FILT_W'(NUM_FILTERS) : num_filt;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        filt_idx_d = filt_idx_q;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d    = clamped_cnt;
                    filt_idx_d = '0;
                    err_d      = 1'b0;
                    state_d    = (clamped_cnt == '0) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (wload_ack) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (core_done) begin
                    if (filt_idx_q == count_q - FILT_W'(1)) begin
                        state_d = ST_FINISH;
                    end else begin
                        filt_idx_d = filt_idx_q + FILT_W'(1);
                        state_d    = ST_LOAD;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides any completion or timeout seen in the same cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            filt_idx_d = filt_idx_q;
            err_d      = err_q;
        end
    end

    // Outputs are decoded from the next state so they are registered yet
    // aligned with the state they describe.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            filt_idx_q   <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            wload_req_q  <= 1'b0;
            wload_idx_q  <= '0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            filt_idx_q   <= filt_idx_d;
            err_q        <= err_d;
            busy_q       <= (state_d != ST_IDLE);
            wload_req_q  <= (state_d == ST_LOAD);
            wload_idx_q  <= (state_d == ST_LOAD) ? filt_idx_d : '0;
            core_start_q <= (state_d == ST_LAUNCH);
            done_q       <= (state_d == ST_FINISH);
        end
    end

    assign busy       = busy_q;
    assign wload_req  = wload_req_q;
    assign wload_idx  = wload_idx_q;
    assign core_start = core_start_q;
    assign done       = done_q;
    assign filt_idx   = filt_idx_q;
    assign err        = err_q;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: cycle-by-cycle vector table plus job-level
// sequences driven by a small weight-load / conv_core responder.
module tb_conv_sched;

    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [FW-1:0] num_filt;
    logic          abort;
    logic          wload_req;
    logic [FW-1:0] wload_idx;
    logic          wload_ack;
    logic          core_start;
    logic          core_done;
    logic [FW-1:0] filt_idx;
    logic          busy;
    logic          done;
    logic          err;

    int n_cmp  = 0;
    int n_fail = 0;

    conv_sched #(
        .NUM_FILTERS    (8),
        .FILT_W         (FW),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_filt   (num_filt),
        .abort      (abort),
        .wload_req  (wload_req),
        .wload_idx  (wload_idx),
        .wload_ack  (wload_ack),
        .core_start (core_start),
        .core_done  (core_done),
        .filt_idx   (filt_idx),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string         name;
        logic          rst_n;
        logic          st;
        logic [FW-1:0] nf;
        logic          ab;
        logic          ack;
        logic          cdone;
        logic          e_busy;
        logic          e_req;
        logic [FW-1:0] e_idx;
        logic          e_cs;
        logic [FW-1:0] e_filt;
        logic          e_done;
        logic          e_err;
    } vec_t;

    vec_t vecs[20];

    // Job-level responder results
    int js_starts, js_done, js_busy, js_req, js_last;
    int js_idx[$];

    task automatic run_job(input int nf, input int abort_filt, output bit finished);
        int  ack_cnt;
        int  dn_cnt;
        bit  aborted;
        wload_ack = 0; core_done = 0; abort = 0;
        start = 1; num_filt = nf[FW-1:0];
        step();
        start = 0;
        js_starts = 0; js_done = 0; js_busy = 0; js_req = 0; js_last = -1;
        js_idx.delete();
        ack_cnt = -1; dn_cnt = -1; aborted = 0; finished = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (aborted) begin
                check("abort_idle", busy, 0);
                check("abort_no_done", done, 0);
                abort = 0;
                finished = 1;
                break;
            end
            if (busy)       js_busy++;
            if (wload_req)  js_req++;
            if (core_start) begin js_starts++; js_last = int'(filt_idx); end
            if (done)       js_done++;
            if (!busy) begin
                finished = 1;
                break;
            end
            wload_ack = 0; core_done = 0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin wload_ack = 1; ack_cnt = -1; end
            end else if (wload_req) begin
                js_idx.push_back(int'(wload_idx));
                ack_cnt = 2;
            end
            if (dn_cnt > 0) begin
                dn_cnt--;
                if (dn_cnt == 0) begin
                    core_done = 1; dn_cnt = -1;
                    if (abort_filt == int'(filt_idx)) begin abort = 1; aborted = 1; end
                end
            end else if (core_start) begin
                dn_cnt = 10;
            end
            step();
        end
        wload_ack = 0; core_done = 0; abort = 0;
    endtask

    initial begin
        bit fin;

        //           name          rst st nf  ab ack cd | busy req idx cs filt done err
        vecs[0]  = '{"rst_hold",    0, 0, 4'd0, 0, 0, 0,  0, 0, 4'd0, 0, 4'd0, 0, 0};
        vecs[1]  = '{"idle",        1, 0, 4'd0, 0, 0, 0,  0, 0, 4'd0, 0, 4'd0, 0, 0};
        vecs[2]  = '{"start2",      1, 1, 4'd2, 0, 0, 0,  1, 1, 4'd0, 0, 4'd0, 0, 0};
        vecs[3]  = '{"load_wait",   1, 0, 4'd0, 0, 0, 0,  1, 1, 4'd0, 0, 4'd0, 0, 0};
        vecs[4]  = '{"ack0",        1, 0, 4'd0, 0, 1, 0,  1, 0, 4'd0, 1, 4'd0, 0, 0};
        vecs[5]  = '{"cd_in_launch",1, 0, 4'd0, 0, 0, 1,  1, 0, 4'd0, 0, 4'd0, 0, 0};
        vecs[6]  = '{"run_wait",    1, 0, 4'd0, 0, 0, 0,  1, 0, 4'd0, 0, 4'd0, 0, 0};
        vecs[7]  = '{"cd0_start",   1, 1, 4'd5, 0, 0, 1,  1, 1, 4'd1, 0, 4'd1, 0, 0};
        vecs[8]  = '{"ack1",        1, 0, 4'd0, 0, 1, 0,  1, 0, 4'd0, 1, 4'd1, 0, 0};
        vecs[9]  = '{"run1",        1, 0, 4'd0, 0, 0, 0,  1, 0, 4'd0, 0, 4'd1, 0, 0};
        vecs[10] = '{"cd_last",     1, 0, 4'd0, 0, 0, 1,  1, 0, 4'd0, 0, 4'd1, 1, 0};
        vecs[11] = '{"back_idle",   1, 0, 4'd0, 0, 0, 0,  0, 0, 4'd0, 0, 4'd1, 0, 0};
        vecs[12] = '{"idle_stray",  1, 0, 4'd0, 0, 1, 1,  0, 0, 4'd0, 0, 4'd1, 0, 0};
        vecs[13] = '{"start0",      1, 1, 4'd0, 0, 0, 0,  1, 0, 4'd0, 0, 4'd0, 1, 0};
        vecs[14] = '{"fin_idle",    1, 0, 4'd0, 0, 0, 0,  0, 0, 4'd0, 0, 4'd0, 0, 0};
        vecs[15] = '{"start1",      1, 1, 4'd1, 0, 0, 0,  1, 1, 4'd0, 0, 4'd0, 0, 0};
        vecs[16] = '{"abort_ack",   1, 0, 4'd0, 1, 1, 0,  0, 0, 4'd0, 0, 4'd0, 0, 0};
        vecs[17] = '{"start1b",     1, 1, 4'd1, 0, 0, 0,  1, 1, 4'd0, 0, 4'd0, 0, 0};
        vecs[18] = '{"rst_in_load", 0, 0, 4'd0, 0, 1, 0,  0, 0, 4'd0, 0, 4'd0, 0, 0};
        vecs[19] = '{"rst_release", 1, 0, 4'd0, 0, 0, 0,  0, 0, 4'd0, 0, 4'd0, 0, 0};

        reset = 0; start = 0; num_filt = '0; abort = 0; wload_ack = 0; core_done = 0;
        step();
        step();

        for (int i = 0; i < 20; i++) begin
            reset     = vecs[i].rst_n;
            start     = vecs[i].st;
            num_filt  = vecs[i].nf;
            abort     = vecs[i].ab;
            wload_ack = vecs[i].ack;
            core_done = vecs[i].cdone;
            step();
            check({vecs[i].name, ".busy"},       busy,       vecs[i].e_busy);
            check({vecs[i].name, ".wload_req"},  wload_req,  vecs[i].e_req);
            check({vecs[i].name, ".wload_idx"},  wload_idx,  vecs[i].e_idx);
            check({vecs[i].name, ".core_start"}, core_start, vecs[i].e_cs);
            check({vecs[i].name, ".filt_idx"},   filt_idx,   vecs[i].e_filt);
            check({vecs[i].name, ".done"},       done,       vecs[i].e_done);
            check({vecs[i].name, ".err"},        err,        vecs[i].e_err);
        end
        start = 0; wload_ack = 0; core_done = 0; abort = 0; reset = 1;
        step();

        // Three filters with delayed acks and completions
        run_job(3, -1, fin);
        check("job3.finished", fin, 1);
        check("job3.starts", js_starts, 3);
        check("job3.done", js_done, 1);
        check("job3.nloads", js_idx.size(), 3);
        for (int i = 0; i < js_idx.size(); i++) check($sformatf("job3.wload_idx%0d", i), js_idx[i], i);
        check("job3.busy_after", busy, 0);

        // Zero filters: FINISH only
        run_job(0, -1, fin);
        check("job0.finished", fin, 1);
        check("job0.busy_cycles", js_busy, 1);
        check("job0.done", js_done, 1);
        check("job0.req_cycles", js_req, 0);
        check("job0.starts", js_starts, 0);

        // Oversized request clamps to NUM_FILTERS
        run_job(15, -1, fin);
        check("job15.finished", fin, 1);
        check("job15.starts", js_starts, 8);
        check("job15.last_idx", js_last, 7);
        check("job15.nloads", js_idx.size(), 8);
        check("job15.done", js_done, 1);

        // Abort coinciding with core_done on filter 1
        run_job(3, 1, fin);
        check("jobab.finished", fin, 1);
        check("jobab.starts", js_starts, 2);
        check("jobab.done", js_done, 0);
        run_job(2, -1, fin);
        check("jobpost.finished", fin, 1);
        check("jobpost.starts", js_starts, 2);
        check("jobpost.done", js_done, 1);

        // Withheld core_done
        start = 1; num_filt = 4'd1;
        step();
        start = 0; wload_ack = 1;
        step();
        wload_ack = 0;
        check("wd.launch", core_start, 1);
`ifdef CONV_SCHED_TIMEOUT_EN
        repeat (20) step();
        check("wd.err_before", err, 0);
        check("wd.busy_before", busy, 1);
        step();
        check("wd.err_set", err, 1);
        check("wd.busy_after", busy, 0);
        check("wd.no_done", done, 0);
        start = 1; num_filt = 4'd0;
        step();
        start = 0;
        check("wd.err_cleared", err, 0);
        check("wd.fin_done", done, 1);
        step();
`else
        repeat (30) step();
        check("nowd.err", err, 0);
        check("nowd.still_busy", busy, 1);
        check("nowd.no_done", done, 0);
        abort = 1;
        step();
        abort = 0;
        check("nowd.abort_idle", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
